debounce_array: RTL and testbench

DEBOUNCE_ARRAY -- requirements
Module: debounce_array

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 150 +++++++++++++++
 rtl/debounce_array.sv | 40 ++++
 tb/tb_debounce_array.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and parameter-range constants for the debounce_array block.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  localparam int unsigned CHANNELS_MIN    = 1;
  localparam int unsigned CHANNELS_MAX    = 32;
  localparam int unsigned LIMIT_MIN       = 2;
  localparam int unsigned LIMIT_MAX       = (1 << 24) - 1;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single debounce channel: input synchroniser, four-state FSM, stability counter
// and, when DEBOUNCE_REPEAT_EN is defined, an auto-repeat counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned LIMIT         = 650000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RESET_LEVEL   = 0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic o,
  output logic rise_o,
  output logic fall_o,
  output logic rpt_o
);

  localparam int unsigned   CW        = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LIMIT - 1);
  localparam logic          RST_LVL   = (RESET_LEVEL != 0);
  localparam deb_state_t    RST_STATE = RST_LVL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  deb_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   o_q, o_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in};
    state_d = state_q;
    cnt_d   = '0;
    o_d     = o_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          o_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          o_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RST_LVL}};
      state_q <= RST_STATE;
      cnt_q   <= '0;
      o_q     <= RST_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o      = o_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic          hold_hi;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [RW-1:0] rcnt_last;
  logic          rep_q, rep_d;
  logic          rpt_q, rpt_d;

  // Repeat timing only advances while the channel stays in STABLE_HI; any
  // excursion (including WAIT_LO) restarts the full initial delay.
  assign hold_hi = (state_q == STABLE_HI) && s;

  always_comb begin
    rcnt_d    = '0;
    rep_d     = 1'b0;
    rpt_d     = 1'b0;
    rcnt_last = rep_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    if (hold_hi) begin
      rep_d = rep_q;
      if (rcnt_q == rcnt_last) begin
        rpt_d = 1'b1;
        rep_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
      rpt_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rep_q  <= rep_d;
      rpt_q  <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// Array of independent debounce channels; auto-repeat is built only when
// DEBOUNCE_REPEAT_EN is defined.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned LIMIT         = 650000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RESET_LEVEL   = 0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] rpt_o
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .LIMIT        (LIMIT),
      .SYNC_STAGES  (SYNC_STAGES),
      .RESET_LEVEL  (RESET_LEVEL),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in[i]),
      .o     (o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i]),
      .rpt_o (rpt_o[i])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// Self-checking bench for debounce_array: directed scenarios plus random input
// bursts compared every cycle against a run-length reference model.
module tb_debounce_array;

  localparam int CH = 4;
  localparam int LIM = 8;
  localparam int SS = 2;
  localparam int RL = 0;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] in_r = '0;
  logic [CH-1:0] o, rise_o, fall_o, rpt_o;

  int errors = 0;
  int checks = 0;
  int fall2_seen = 0;

  always #5 clk = ~clk;

  debounce_array #(
    .CHANNELS     (CH),
    .LIMIT        (LIM),
    .SYNC_STAGES  (SS),
    .RESET_LEVEL  (RL),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_r),
    .o     (o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .rpt_o (rpt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel flips its level once the synchronised input
  // has disagreed with it for LIM consecutive edges.
  logic [CH-1:0] in_smp;
  logic          rst_smp = 1'b0;
  int            mq[CH][$];
  logic [CH-1:0] m_o;
  int            m_run[CH];
  int            m_age[CH];
  logic [CH-1:0] e_rise, e_fall, e_rpt;

  always @(posedge clk) begin
    in_smp  <= in_r;
    rst_smp <= rst_n;
  end

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      for (int k = 0; k < SS; k++) mq[c].push_back(RL);
      m_o[c]   = (RL != 0);
      m_run[c] = 0;
      m_age[c] = 0;
    end
    e_rise = '0;
    e_fall = '0;
    e_rpt  = '0;
  endtask

  task automatic model_step();
    int s;
    e_rise = '0;
    e_fall = '0;
    e_rpt  = '0;
    for (int c = 0; c < CH; c++) begin
      s = mq[c].pop_front();
      mq[c].push_back(int'(in_smp[c]));
      if (s != int'(m_o[c])) begin
        m_run[c]++;
        m_age[c] = 0;
        if (m_run[c] == LIM) begin
          m_o[c]   = (s != 0);
          m_run[c] = 0;
          if (s != 0) e_rise[c] = 1'b1;
          else        e_fall[c] = 1'b1;
        end
      end else if (m_run[c] > 0) begin
        m_run[c] = 0;
        m_age[c] = 0;
      end else if (m_o[c]) begin
        m_age[c]++;
`ifdef DEBOUNCE_REPEAT_EN
        if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0))
          e_rpt[c] = 1'b1;
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n || !rst_smp) model_reset();
    else model_step();
    chk("o", 32'(o), 32'(m_o));
    chk("rise_o", 32'(rise_o), 32'(e_rise));
    chk("fall_o", 32'(fall_o), 32'(e_fall));
    chk("rpt_o", 32'(rpt_o), 32'(e_rpt));
    if (fall_o[2]) fall2_seen++;
  end

  // Advance n edges and land 2 time units after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int hold[CH];

  initial begin
    rst_n = 1'b0;
    in_r  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o", 32'(o), 32'h0);
    chk("reset_pulses", 32'(rise_o | fall_o | rpt_o), 32'h0);
    #1;
    rst_n = 1'b1;
    step(3);

    // Single channel held high: accepted on edge SS+LIM = 10.
    in_r[0] = 1'b1;
    repeat (9) @(posedge clk);
    #1 chk("lat_o_edge9", 32'(o[0]), 32'd0);
    @(posedge clk);
    #1 chk("lat_o_edge10", 32'(o[0]), 32'd1);
    chk("lat_rise_edge10", 32'(rise_o[0]), 32'd1);
    @(posedge clk);
    #1 chk("lat_rise_edge11", 32'(rise_o[0]), 32'd0);
    #1;

    // Seven-cycle glitch rejected, eight-cycle level accepted.
    in_r[1] = 1'b1;
    step(7);
    in_r[1] = 1'b0;
    step(12);
    chk("short_pulse_o1", 32'(o[1]), 32'd0);
    in_r[1] = 1'b1;
    step(12);
    chk("long_pulse_o1", 32'(o[1]), 32'd1);

    // Chatter on a high channel never lowers it.
    in_r[2] = 1'b1;
    step(12);
    chk("chatter_pre_o2", 32'(o[2]), 32'd1);
    fall2_seen = 0;
    for (int k = 0; k < 34; k++) begin
      in_r[2] = ~in_r[2];
      step(3);
    end
    in_r[2] = 1'b1;
    step(12);
    chk("chatter_o2", 32'(o[2]), 32'd1);
    chk("chatter_no_fall2", 32'(fall2_seen), 32'd0);

    // All channels rise on the same edge.
    in_r = '0;
    step(14);
    chk("all_low", 32'(o), 32'h0);
    in_r = '1;
    repeat (9) @(posedge clk);
    #1 chk("all_rise_edge9", 32'(rise_o), 32'h0);
    @(posedge clk);
    #1 chk("all_rise_edge10", 32'(rise_o), 32'hF);
    #1;

`ifdef DEBOUNCE_REPEAT_EN
    // Repeat pulses 20, 25 and 30 cycles after rise_o[0].
    in_r = '0;
    step(14);
    in_r[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("rpt_rise0", 32'(rise_o[0]), 32'd1);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1 chk("rpt_pulse0", 32'(rpt_o[0]), 32'((k == 20 || k == 25 || k == 30) ? 1 : 0));
    end
    #1;
    in_r = '1;
    step(14);
`endif

    // Reset during WAIT_HI aborts the pending rise.
    in_r[3] = 1'b0;
    step(14);
    in_r[3] = 1'b1;
    step(5);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_o", 32'(o), 32'h0);
    chk("midwait_rst_pulses", 32'(rise_o | fall_o | rpt_o), 32'h0);
    in_r = '0;
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("after_rst_o", 32'(o), 32'h0);

    // Random bursts, mostly short with occasional long holds.
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          in_r[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 6) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 12));
        end
        hold[c]--;
      end
      if (cyc == 1500) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
